// File: rtl/traffic_junction_ctrl_pkg.sv
// Shared types and light codes for the junction controller.
package traffic_pkg;

  // Phase encoding; the numeric values are exposed on the debug port.
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    PED_WALK    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6
  } state_e;

  // Light head codes, index 0 = red, 1 = green, 2 = yellow.
  localparam logic [0:2] LIGHT_RED = 3'b100;
  localparam logic [0:2] LIGHT_GRN = 3'b010;
  localparam logic [0:2] LIGHT_YEL = 3'b001;

endpackage

// File: rtl/traffic_junction_ctrl_phase_timer.sv
// Loadable down-counter that parks at zero; done flags an expired phase.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset to the initial phase length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/traffic_junction_ctrl.sv
// Junction sequencer: main road rests on green, side cars and pedestrian
// requests are served in a fixed timed order with all-red clearance.
module traffic_junction_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MAIN_MIN = 8,
  parameter int SIDE_G   = 6,
  parameter int YEL_T    = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       ped_btn,
  output logic [0:2] main_light,
  output logic [0:2] side_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  state_e           state_q;
  state_e           state_d;
  logic             ped_pending_q;
  logic             ped_pending_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;
  logic             timer_done;

  // Value loaded on entry so that each timed phase lasts exactly its duration.
  function automatic logic [CNT_W-1:0] dur_m1(input state_e s);
    case (s)
      MAIN_GREEN:  return CNT_W'(MAIN_MIN - 1);
      MAIN_YELLOW: return CNT_W'(YEL_T - 1);
      ALL_RED_A:   return CNT_W'(ALLRED_T - 1);
      PED_WALK:    return CNT_W'(PED_T - 1);
      SIDE_GREEN:  return CNT_W'(SIDE_G - 1);
      SIDE_YELLOW: return CNT_W'(YEL_T - 1);
      default:     return CNT_W'(ALLRED_T - 1);
    endcase
  endfunction

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(ALLRED_T - 1))
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .load_val(timer_load_val),
    .done    (timer_done)
  );

  // Next phase, timer reload on phase change, and pedestrian latch update.
  always_comb begin
    state_d        = state_q;
    timer_load     = 1'b0;
    timer_load_val = '0;
    ped_pending_d  = ped_pending_q;

    if (timer_done) begin
      case (state_q)
        MAIN_GREEN:  if (side_req | ped_pending_q | ped_btn) state_d = MAIN_YELLOW;
        MAIN_YELLOW: state_d = ALL_RED_A;
        ALL_RED_A:   state_d = (ped_pending_q | ped_btn) ? PED_WALK : SIDE_GREEN;
        PED_WALK:    state_d = side_req ? SIDE_GREEN : ALL_RED_B;
        SIDE_GREEN:  state_d = SIDE_YELLOW;
        SIDE_YELLOW: state_d = ALL_RED_B;
        ALL_RED_B:   state_d = MAIN_GREEN;
        default:     state_d = ALL_RED_B;
      endcase
    end

    if (state_d != state_q) begin
      timer_load     = 1'b1;
      timer_load_val = dur_m1(state_d);
    end

    // Presses outside the walk are latched; entering the walk consumes them.
    if (ped_btn && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b1;
    end
    if ((state_d == PED_WALK) && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b0;
    end
  end

  // Phase and pending-request registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ALL_RED_B;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Moore decode of the light heads and walk lamp from the phase register.
  always_comb begin
    main_light = LIGHT_RED;
    side_light = LIGHT_RED;
    ped_walk   = 1'b0;
    case (state_q)
      MAIN_GREEN:  main_light = LIGHT_GRN;
      MAIN_YELLOW: main_light = LIGHT_YEL;
      PED_WALK:    ped_walk   = 1'b1;
      SIDE_GREEN:  side_light = LIGHT_GRN;
      SIDE_YELLOW: side_light = LIGHT_YEL;
      default:     ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: doc/traffic_junction_ctrl.md
Name: traffic_junction_ctrl

Overview:
Sequencing controller for a two-road junction: main road, side road and a pedestrian crossing. Drives two 3-bit R-G-Y light heads and a walk signal. Main road rests on green. Side-road car demand and latched pedestrian requests are served in a fixed, timed phase order, with all-red clearance between conflicting greens. Sits above the light heads and is the only writer of their light codes.

Parameters:
CNT_W, 8, phase-timer width; every duration must be >=1 and <=2^CNT_W-1
MAIN_MIN, 8, minimum main-green dwell in cycles
SIDE_G, 6, side-green dwell in cycles
YEL_T, 3, yellow dwell in cycles (both roads)
ALLRED_T, 2, all-red clearance dwell in cycles
PED_T, 5, pedestrian walk dwell in cycles

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
side_req  in  1  side-road car sensor, level
ped_btn  in  1  pedestrian button, pulse of >=1 cycle
main_light  out  [0:2]  main head; bit0=R, bit1=G, bit2=Y; 100 red, 010 green, 001 yellow
side_light  out  [0:2]  side head, same encoding
ped_walk  out  1  walk lamp
phase  out  3  current state encoding, for debug

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge of clk only.
- Reset: state=ALL_RED_B; timer=ALLRED_T-1; ped_pending=0; main_light=100; side_light=100; ped_walk=0.
- Outputs are Moore-decoded from the state register and change on the same edge as the state.
- States and lights (main/side/walk):
  - MAIN_GREEN: 010/100/0
  - MAIN_YELLOW: 001/100/0
  - ALL_RED_A: 100/100/0
  - PED_WALK: 100/100/1
  - SIDE_GREEN: 100/010/0
  - SIDE_YELLOW: 100/001/0
  - ALL_RED_B: 100/100/0
- Timer:
  - On state entry, timer loads DUR-1, where DUR is that state's duration parameter.
  - The timer decrements each cycle and is held at 0.
  - Timed states therefore last exactly DUR cycles.
- Transitions (evaluated when timer==0):
  - MAIN_GREEN: go to MAIN_YELLOW if (side_req | ped_pending | ped_btn); otherwise stay, timer held at 0. Demand arriving before MAIN_MIN expires waits for expiry.
  - MAIN_YELLOW goes to ALL_RED_A.
  - ALL_RED_A goes to PED_WALK if (ped_pending | ped_btn); otherwise to SIDE_GREEN.
  - PED_WALK goes to SIDE_GREEN if side_req is sampled high in its last cycle; otherwise to ALL_RED_B.
  - SIDE_GREEN goes to SIDE_YELLOW after the fixed SIDE_G dwell. It is not extended by side_req.
  - SIDE_YELLOW goes to ALL_RED_B.
  - ALL_RED_B goes to MAIN_GREEN.
- ped_pending:
  - Set in any cycle with ped_btn=1 while the state is not PED_WALK.
  - Cleared on the edge that enters PED_WALK.
  - ped_btn during PED_WALK is ignored.
  - When a set and a clear coincide, the clear wins. The press is consumed by the walk being entered.
- Safety invariants, which must hold every cycle:
  - Never both heads non-red.
  - ped_walk=1 only while both heads are red.
  - Only legal light codes appear.
- Reset mid-operation: the next edge with rst_n=0 forces the reset values regardless of state or timer.

Decomposition:
- Package traffic_pkg holds:
  - state enum (3-bit) with encodings MAIN_GREEN=0 .. ALL_RED_B=6
  - light constants LIGHT_RED=3'b100, LIGHT_GRN=3'b010, LIGHT_YEL=3'b001
- One sub-module, phase_timer: a loadable CNT_W down-counter.
  - Inputs: load, load_val, rst_n.
  - Output: done (timer==0).
  - It saturates at 0.

Test Plan:
1. Release rst_n with no requests: both heads 100 for exactly 2 cycles, then main 010 and side 100. Main stays 010 for 50+ cycles; ped_walk stays 0.
2. side_req held high from main-green entry: 8 cycles main 010, 3 cycles 001, 2 cycles all-red, 6 cycles side 010, 3 cycles side 001, 2 cycles all-red, then main 010. Period is 24 cycles while side_req stays high.
3. One-cycle ped_btn at main-green cycle 3, side_req=0: green ends after 8 cycles, then Y3, AR2, then 5 cycles of ped_walk=1 with both heads 100, then AR2, then main 010. ped_pending is 0 after walk entry.
4. ped_btn pulse plus side_req held: green 8, Y3, AR2, PED_WALK 5, then side 010 directly with no extra all-red, then side Y3, AR2, main green.
5. ped_btn during PED_WALK: no second walk. ped_btn during SIDE_GREEN: latched, and served on the next main-green exit once MAIN_MIN (8 cycles) has expired.
6. rst_n low for 1 cycle at side-green cycle 2: next edge gives both heads 100, ped_walk=0, phase=6 and ped_pending=0. After 2 cycles, main 010. The invariant checker runs throughout all tests.
